// File: rtl/uart_word_packer.sv
// uart_word_packer
//   Collects WORD_BYTES bytes from the UART RX interface into one operand word
//   for the crypter and offers it on a valid/ready handshake. An end-of-
//   transmission marker flushes any partial word (possibly empty), marked last.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   rx_readable   RX interface holds an unread byte/marker (level)
//   eot           pending item is an end-of-transmission marker, not data
//   rx_data       pending byte, stable while rx_readable=1
//   rx_used_tick  one-cycle pulse: pending item consumed
//   word          packed word, stable while word_valid=1
//   word_bytes    number of valid bytes in word
//   word_last     word closes the transmission
//   word_valid    word offered, held until word_ready
//   word_ready    consumer accepts word when word_valid & word_ready
//
// Optional feature
//   PACKER_TIMEOUT_EN: discard a partial word after TIMEOUT_CYCLES idle cycles
//   between bytes. Without the macro a partial word waits indefinitely.

module uart_word_packer #(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned MSB_FIRST      = 1
`ifdef PACKER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 524288
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx_readable,
  input  logic                               eot,
  input  logic [7:0]                         rx_data,
  output logic                               rx_used_tick,
  output logic [8*WORD_BYTES-1:0]            word,
  output logic [$clog2(WORD_BYTES+1)-1:0]    word_bytes,
  output logic                               word_last,
  output logic                               word_valid,
  input  logic                               word_ready
);

  localparam int unsigned W  = 8 * WORD_BYTES;
  localparam int unsigned CW = $clog2(WORD_BYTES + 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ACK     = 2'd1,
    S_GUARD   = 2'd2,
    S_OFFER   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic            eot_seen_q, eot_seen_d;
  logic [W-1:0]    word_d;
  logic [CW-1:0]   word_bytes_d;
  logic            word_last_d;
  logic            word_valid_d;
  logic            rx_used_tick_d;
  logic            word_full_c;
  logic            timeout_hit_c;

  // Low bit position of byte slot i inside the word
  function automatic int unsigned slot_lo(input int unsigned i);
    if (MSB_FIRST != 0) return W - 8 - 8 * i;
    else                return 8 * i;
  endfunction

  assign word_full_c = (cnt_q == CW'(WORD_BYTES));

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          tmo_run_c;

  // Idle counter only runs while a partial word waits for its next byte
  assign tmo_run_c     = (state_q == S_COLLECT) && (cnt_q != '0) && !rx_readable;
  assign timeout_hit_c = tmo_run_c && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (tmo_run_c && !timeout_hit_c) begin
      tmo_q <= tmo_q + TW'(1);
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign timeout_hit_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_COLLECT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (rx_readable) state_d = S_ACK;
      S_ACK:     state_d = S_GUARD;
      // RX flag is still clearing here, so rx_readable is not looked at
      S_GUARD:   state_d = (eot_seen_q || word_full_c) ? S_OFFER : S_COLLECT;
      S_OFFER:   if (word_ready) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    eot_seen_d     = eot_seen_q;
    word_d         = word;
    word_bytes_d   = word_bytes;
    word_last_d    = word_last;
    rx_used_tick_d = (state_d == S_ACK);
    word_valid_d   = (state_d == S_OFFER);

    unique case (state_q)
      S_COLLECT: begin
        if (rx_readable) begin
          eot_seen_d = eot;
          if (!eot) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
              if (cnt_q == CW'(i)) shreg_d[slot_lo(i) +: 8] = rx_data;
            end
            cnt_d = cnt_q + CW'(1);
          end
        end else if (timeout_hit_c) begin
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      S_GUARD: begin
        // Unused slots are already zero, so an empty close presents word=0
        if (eot_seen_q || word_full_c) begin
          word_d       = shreg_q;
          word_bytes_d = cnt_q;
          word_last_d  = eot_seen_q;
        end
      end
      S_OFFER: begin
        if (word_ready) begin
          cnt_d      = '0;
          shreg_d    = '0;
          eot_seen_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      eot_seen_q   <= 1'b0;
      word         <= '0;
      word_bytes   <= '0;
      word_last    <= 1'b0;
      word_valid   <= 1'b0;
      rx_used_tick <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      eot_seen_q   <= eot_seen_d;
      word         <= word_d;
      word_bytes   <= word_bytes_d;
      word_last    <= word_last_d;
      word_valid   <= word_valid_d;
      rx_used_tick <= rx_used_tick_d;
    end
  end

endmodule

// File: tb/tb_uart_word_packer.sv
module tb_uart_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_readable = 1'b0;
  logic        eot = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        word_ready = 1'b0;

  logic        tick0, tick1;
  logic [31:0] word0, word1;
  logic [2:0]  wb0, wb1;
  logic        last0, last1, valid0, valid1;

  logic        push = 1'b0;
  logic        push_eot = 1'b0;
  logic [7:0]  push_data = 8'h00;
  int          tick_cnt0 = 0;
  int          tick_cnt1 = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

`ifdef PACKER_TIMEOUT_EN
  uart_word_packer #(.WORD_BYTES(4), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)) u_msb (
`else
  uart_word_packer #(.WORD_BYTES(4), .MSB_FIRST(1)) u_msb (
`endif
    .clk(clk), .rst(rst), .rx_readable(rx_readable), .eot(eot), .rx_data(rx_data),
    .rx_used_tick(tick0), .word(word0), .word_bytes(wb0), .word_last(last0),
    .word_valid(valid0), .word_ready(word_ready));

`ifdef PACKER_TIMEOUT_EN
  uart_word_packer #(.WORD_BYTES(4), .MSB_FIRST(0), .TIMEOUT_CYCLES(16)) u_lsb (
`else
  uart_word_packer #(.WORD_BYTES(4), .MSB_FIRST(0)) u_lsb (
`endif
    .clk(clk), .rst(rst), .rx_readable(rx_readable), .eot(eot), .rx_data(rx_data),
    .rx_used_tick(tick1), .word(word1), .word_bytes(wb1), .word_last(last1),
    .word_valid(valid1), .word_ready(word_ready));

  // RX interface model: one pending item, cleared by the consume pulse.
  // Both DUTs run in lockstep on shared stimulus; u_msb's pulse clears the flag.
  always @(posedge clk) begin
    if (rst) rx_readable <= 1'b0;
    else if (push) begin
      rx_readable <= 1'b1;
      rx_data     <= push_data;
      eot         <= push_eot;
    end else if (tick0) rx_readable <= 1'b0;
    if (tick0) tick_cnt0 <= tick_cnt0 + 1;
    if (tick1) tick_cnt1 <= tick_cnt1 + 1;
  end

  // Offer one item once the RX flag is free; returns on the negedge after it is set
  task automatic push_item(input logic [7:0] d, input logic e);
    int n = 0;
    while (rx_readable && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rx_readable) begin
      tests++; fails++;
      $display("FAIL push_timeout: rx_readable stuck at %0b, required 0", rx_readable);
    end
    push_data = d;
    push_eot  = e;
    push      = 1'b1;
    @(negedge clk);
    push      = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!valid0) begin
      fails++;
      $display("FAIL wait_valid: word_valid=%0b after %0d cycles, required 1", valid0, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    tests++;
    if ({word0, wb0, last0, valid0, tick0} !== 38'd0) begin
      fails++;
      $display("FAIL reset_msb: got %h/%0d/%0b/%0b/%0b required all 0", word0, wb0, last0, valid0, tick0);
    end
    tests++;
    if ({word1, wb1, last1, valid1, tick1} !== 38'd0) begin
      fails++;
      $display("FAIL reset_lsb: got %h/%0d/%0b/%0b/%0b required all 0", word1, wb1, last1, valid1, tick1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_msb_first();
    int t0 = tick_cnt0;
    int t1 = tick_cnt1;
    int cyc;
    word_ready = 1'b1;
    push_item(8'h11, 1'b0);
    push_item(8'h22, 1'b0);
    push_item(8'h33, 1'b0);
    push_item(8'h44, 1'b0);
    wait_valid(cyc);
    tests++;
    if (cyc !== 3) begin
      fails++;
      $display("FAIL latency: got %0d cycles, required 3", cyc);
    end
    tests++;
    if ({word0, wb0, last0} !== {32'h11223344, 3'd4, 1'b0}) begin
      fails++;
      $display("FAIL msb_word: got %h/%0d/%0b required 11223344/4/0", word0, wb0, last0);
    end
    @(negedge clk);
    tests++;
    if (valid0 !== 1'b0) begin
      fails++;
      $display("FAIL msb_accept: word_valid=%0b required 0", valid0);
    end
    tests++;
    if ((tick_cnt0 - t0) !== 4 || (tick_cnt1 - t1) !== 4) begin
      fails++;
      $display("FAIL msb_ticks: got %0d/%0d pulses required 4/4", tick_cnt0 - t0, tick_cnt1 - t1);
    end
    word_ready = 1'b0;
  endtask

  task automatic test_lsb_first();
    int cyc;
    word_ready = 1'b1;
    push_item(8'h11, 1'b0);
    push_item(8'h22, 1'b0);
    push_item(8'h33, 1'b0);
    push_item(8'h44, 1'b0);
    wait_valid(cyc);
    tests++;
    if ({valid1, word1, wb1, last1} !== {1'b1, 32'h44332211, 3'd4, 1'b0}) begin
      fails++;
      $display("FAIL lsb_word: got %0b/%h/%0d/%0b required 1/44332211/4/0", valid1, word1, wb1, last1);
    end
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_eot_flush();
    int t0 = tick_cnt0;
    int cyc;
    word_ready = 1'b1;
    push_item(8'hAA, 1'b0);
    push_item(8'hBB, 1'b0);
    push_item(8'h00, 1'b1);
    wait_valid(cyc);
    tests++;
    if ({word0, wb0, last0} !== {32'hAABB0000, 3'd2, 1'b1}) begin
      fails++;
      $display("FAIL eot_msb: got %h/%0d/%0b required AABB0000/2/1", word0, wb0, last0);
    end
    tests++;
    if ({word1, wb1, last1} !== {32'h0000BBAA, 3'd2, 1'b1}) begin
      fails++;
      $display("FAIL eot_lsb: got %h/%0d/%0b required 0000BBAA/2/1", word1, wb1, last1);
    end
    @(negedge clk);
    tests++;
    if ((tick_cnt0 - t0) !== 3) begin
      fails++;
      $display("FAIL eot_ticks: got %0d pulses required 3", tick_cnt0 - t0);
    end
    word_ready = 1'b0;
  endtask

  task automatic test_empty_close();
    int cyc;
    word_ready = 1'b0;
    push_item(8'h5A, 1'b1);
    wait_valid(cyc);
    tests++;
    if ({word0, wb0, last0} !== {32'h0, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL empty_close: got %h/%0d/%0b required 00000000/0/1", word0, wb0, last0);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (valid0 !== 1'b0) begin
      fails++;
      $display("FAIL empty_once: word_valid=%0b required 0", valid0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int t0;
    int bad = 0;
    word_ready = 1'b0;
    push_item(8'hDE, 1'b0);
    push_item(8'hAD, 1'b0);
    push_item(8'hBE, 1'b0);
    push_item(8'hEF, 1'b0);
    wait_valid(cyc);
    push_item(8'h01, 1'b0);
    t0 = tick_cnt0;
    repeat (20) begin
      @(negedge clk);
      if (valid0 !== 1'b1 || word0 !== 32'hDEADBEEF || rx_readable !== 1'b1) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_stable: %0d unstable cycles required 0 (word %h)", bad, word0);
    end
    tests++;
    if ((tick_cnt0 - t0) !== 0) begin
      fails++;
      $display("FAIL hold_no_consume: got %0d pulses required 0", tick_cnt0 - t0);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    tests++;
    if (valid0 !== 1'b0) begin
      fails++;
      $display("FAIL hold_accept: word_valid=%0b required 0", valid0);
    end
    push_item(8'h02, 1'b0);
    push_item(8'h03, 1'b0);
    push_item(8'h04, 1'b0);
    wait_valid(cyc);
    tests++;
    if ({word0, wb0, last0, word1} !== {32'h01020304, 3'd4, 1'b0, 32'h04030201}) begin
      fails++;
      $display("FAIL after_hold: got %h/%0d/%0b/%h required 01020304/4/0/04030201", word0, wb0, last0, word1);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    int cyc;
    push_item(8'h55, 1'b0);
    push_item(8'h66, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({word0, wb0, last0, valid0, tick0} !== 38'd0) begin
      fails++;
      $display("FAIL mid_reset: got %h/%0d/%0b/%0b/%0b required all 0", word0, wb0, last0, valid0, tick0);
    end
    rst = 1'b0;
    @(negedge clk);
    push_item(8'h00, 1'b1);
    wait_valid(cyc);
    tests++;
    if ({word0, wb0, last0} !== {32'h0, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL mid_reset_discard: got %h/%0d/%0b required 00000000/0/1", word0, wb0, last0);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

`ifdef PACKER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    word_ready = 1'b0;
    push_item(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    push_item(8'h01, 1'b0);
    push_item(8'h02, 1'b0);
    push_item(8'h03, 1'b0);
    push_item(8'h04, 1'b0);
    wait_valid(cyc);
    tests++;
    if ({word0, wb0, last0} !== {32'h01020304, 3'd4, 1'b0}) begin
      fails++;
      $display("FAIL timeout_discard: got %h/%0d/%0b required 01020304/4/0", word0, wb0, last0);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_eot_flush();
    test_empty_close();
    test_back_to_back();
    test_reset_mid_word();
`ifdef PACKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
